// File: rtl/conv2d_pkg.sv
// -----------------------------------------------------------------------------
// conv2d_pkg
// Constants and types shared by the conv2d window buffer and the conv2d
// accelerator, so that both sides agree on pixel width and window layout.
//   CONV2D_FILTER_SIZE : default window edge length
//   CONV2D_DATA_WIDTH  : default pixel width
//   pixel_t            : one pixel
//   patch_t            : FILTER_SIZE x FILTER_SIZE window, [0][0] = top-left
//   ctrWidth()         : bit width for a counter that indexes 0..n-1
// -----------------------------------------------------------------------------
package conv2d_pkg;

  localparam int CONV2D_FILTER_SIZE = 3;
  localparam int CONV2D_DATA_WIDTH  = 8;

  typedef logic [CONV2D_DATA_WIDTH-1:0] pixel_t;
  typedef pixel_t [CONV2D_FILTER_SIZE-1:0][CONV2D_FILTER_SIZE-1:0] patch_t;

  // A one-entry range still needs a one-bit counter.
  function automatic int ctrWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv2d_line_buffer.sv
// -----------------------------------------------------------------------------
// conv2d_line_buffer
// DEPTH-entry shift delay line. Each enabled cycle shifts one entry in; the
// output is the entry written DEPTH enables ago, i.e. the pixel one image row
// above the pixel currently being written when DEPTH equals the row width.
// Storage is intentionally not reset: every location is rewritten before it
// can contribute to a valid window.
//   clk    : clock
//   en_i   : shift enable (one accepted pixel)
//   din_i  : pixel entering the delay line
//   dout_o : pixel leaving the delay line (combinational from storage)
// -----------------------------------------------------------------------------
module conv2d_line_buffer
  import conv2d_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int DATA_WIDTH = CONV2D_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] dout_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Shift register: entry 0 is newest, entry DEPTH-1 is oldest.
  always_ff @(posedge clk) begin
    if (en_i) begin
      mem_q[0] <= din_i;
      for (int k = 1; k < DEPTH; k++) begin
        mem_q[k] <= mem_q[k-1];
      end
    end
  end

  assign dout_o = mem_q[DEPTH-1];

endmodule

// File: rtl/conv2d_window_buffer.sv
// -----------------------------------------------------------------------------
// conv2d_window_buffer
// Turns a raster-order pixel stream into every FILTER_SIZE x FILTER_SIZE patch
// of a no-padding convolution, using FILTER_SIZE-1 line buffers feeding a
// register window. Valid/ready handshake on both the pixel and patch sides.
//   clk          : clock, all state on rising edge
//   rst          : asynchronous active-low reset
//   pixel_in     : input pixel, raster order
//   pixel_valid  : pixel_in valid
//   pixel_sof    : (only with CONV2D_WINBUF_SOF_EN) pixel is (0,0) of a frame
//   pixel_ready  : a pixel is accepted this cycle if valid
//   image_patch  : window, [0][0] = oldest row, oldest column
//   patch_valid  : image_patch valid
//   patch_ready  : downstream takes the patch
//   frame_done   : one-cycle pulse after the last pixel of a frame is accepted
// Optional feature macro: CONV2D_WINBUF_SOF_EN (adds pixel_sof).
// Requires FILTER_SIZE >= 2 and IMG_WIDTH, IMG_HEIGHT >= FILTER_SIZE.
// -----------------------------------------------------------------------------
module conv2d_window_buffer
  import conv2d_pkg::*;
#(
  parameter int FILTER_SIZE = CONV2D_FILTER_SIZE,
  parameter int DATA_WIDTH  = CONV2D_DATA_WIDTH,
  parameter int IMG_WIDTH   = 32,
  parameter int IMG_HEIGHT  = 32
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic [DATA_WIDTH-1:0]                               pixel_in,
  input  logic                                                pixel_valid,
`ifdef CONV2D_WINBUF_SOF_EN
  input  logic                                                pixel_sof,
`endif
  output logic                                                pixel_ready,
  output logic [FILTER_SIZE-1:0][FILTER_SIZE-1:0][DATA_WIDTH-1:0] image_patch,
  output logic                                                patch_valid,
  input  logic                                                patch_ready,
  output logic                                                frame_done
);

  localparam int CW  = ctrWidth(IMG_WIDTH);
  localparam int RW  = ctrWidth(IMG_HEIGHT);
  localparam int NLB = FILTER_SIZE - 1;

  logic          accept;
  logic          sof;
  logic [CW-1:0] col_q, col_d, effCol;
  logic [RW-1:0] row_q, row_d, effRow;
  logic          generate_w;
  logic          lastPixel;
  logic          patchValid_q, patchValid_d;
  logic          frameDone_q, frameDone_d;

  logic [FILTER_SIZE-1:0][FILTER_SIZE-1:0][DATA_WIDTH-1:0] win_q, win_d;
  logic [FILTER_SIZE-1:0][DATA_WIDTH-1:0]                  newCol;
  logic [DATA_WIDTH-1:0]                                   lbIn  [NLB];
  logic [DATA_WIDTH-1:0]                                   lbOut [NLB];

`ifdef CONV2D_WINBUF_SOF_EN
  assign sof = pixel_sof;
`else
  assign sof = 1'b0;
`endif

  assign pixel_ready = !patchValid_q || patch_ready;
  assign accept      = pixel_valid && pixel_ready;

  // A start-of-frame pixel is handled as if the counters already read (0,0);
  // this realigns the frame and keeps it from completing a patch.
  assign effCol     = sof ? '0 : col_q;
  assign effRow     = sof ? '0 : row_q;
  assign generate_w = (effRow >= RW'(FILTER_SIZE-1)) && (effCol >= CW'(FILTER_SIZE-1));
  assign lastPixel  = (effCol == CW'(IMG_WIDTH-1)) && (effRow == RW'(IMG_HEIGHT-1));

  // Line buffers are chained: buffer k delays by k+1 rows.
  for (genvar k = 0; k < NLB; k++) begin : gLine
    if (k == 0) begin : gFirst
      assign lbIn[k] = pixel_in;
    end else begin : gRest
      assign lbIn[k] = lbOut[k-1];
    end
    conv2d_line_buffer #(
      .DEPTH      (IMG_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) uLine (
      .clk    (clk),
      .en_i   (accept),
      .din_i  (lbIn[k]),
      .dout_o (lbOut[k])
    );
  end

  // Column entering the window: deepest line buffer is the oldest row (top).
  always_comb begin
    newCol = '0;
    newCol[FILTER_SIZE-1] = pixel_in;
    for (int i = 0; i < FILTER_SIZE-1; i++) begin
      newCol[i] = lbOut[FILTER_SIZE-2-i];
    end
  end

  // Next-state for position counters, window, and output flags.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    patchValid_d = patchValid_q;
    frameDone_d  = 1'b0;
    if (accept) begin
      if (effCol == CW'(IMG_WIDTH-1)) begin
        col_d = '0;
        row_d = (effRow == RW'(IMG_HEIGHT-1)) ? '0 : effRow + 1'b1;
      end else begin
        col_d = effCol + 1'b1;
        row_d = effRow;
      end
      for (int i = 0; i < FILTER_SIZE; i++) begin
        for (int j = 0; j < FILTER_SIZE-1; j++) begin
          win_d[i][j] = win_q[i][j+1];
        end
        win_d[i][FILTER_SIZE-1] = newCol[i];
      end
      patchValid_d = generate_w;
      frameDone_d  = lastPixel && !sof;
    end else if (patch_ready) begin
      patchValid_d = 1'b0;
    end
  end

  // State registers; line buffer storage is the only unreset state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '0;
      patchValid_q <= 1'b0;
      frameDone_q  <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      patchValid_q <= patchValid_d;
      frameDone_q  <= frameDone_d;
    end
  end

  // The window only moves on accept, and no accept happens while a patch is
  // stalled, so the window itself is the held patch.
  assign image_patch = win_q;
  assign patch_valid = patchValid_q;
  assign frame_done  = frameDone_q;

endmodule
